// File: rtl/ika2151_pkg.sv
// Shared constants and types for the OPM serial-output receiver.
package ika2151_pkg;

   localparam int unsigned WORD_W   = 16;
   localparam int unsigned MANT_LSB = 3;
   localparam int unsigned MANT_MSB = 12;
   localparam int unsigned EXP_LSB  = 13;
   localparam int unsigned MANT_W   = MANT_MSB - MANT_LSB + 1;
   localparam int unsigned EXP_W    = WORD_W - EXP_LSB;
   localparam int unsigned CNT_W    = 5;

   typedef enum logic [1:0] {
      UNLOCKED = 2'd0,
      SYNC     = 2'd1,
      LOCKED   = 2'd2
   } rx_state_e;

endpackage

// File: rtl/ika2151_so_fp2lin.sv
// YM3012-style float word to signed linear PCM converter (or raw pass-through).
module ika2151_so_fp2lin
   import ika2151_pkg::*;
#(
   parameter bit LINEAR_OUT = 1'b1
) (
   input  logic [WORD_W-1:0] i_word,
   output logic [WORD_W-1:0] o_lin_c
);

   logic [EXP_W-1:0]  exp_c;
   logic [MANT_W-1:0] mant_c;
   logic [WORD_W-1:0] ext_c;

   always_comb begin
      exp_c  = i_word[WORD_W-1:EXP_LSB];
      mant_c = i_word[MANT_MSB:MANT_LSB];
      // offset-binary mantissa becomes two's complement by flipping its MSB
      ext_c  = {{(WORD_W - MANT_W){~mant_c[MANT_W-1]}}, ~mant_c[MANT_W-1], mant_c[MANT_W-2:0]};
      o_lin_c = '0;
      if (!LINEAR_OUT) begin
         o_lin_c = i_word;
      end else if (exp_c != '0) begin
         o_lin_c = ext_c << (exp_c - EXP_W'(1));
      end
   end

endmodule

// File: rtl/ika2151_so_rx.sv
// Deserialises SH1/SH2-framed SO words into left/right samples and monitors framing.
module ika2151_so_rx
   import ika2151_pkg::*;
#(
   parameter int unsigned FRAME_LEN  = 32,
   parameter int unsigned SH2_OFFSET = 16,
   parameter bit          LINEAR_OUT = 1'b1
) (
   input  logic              i_EMUCLK,
   input  logic              i_RST,
   input  logic              i_phi1_PCEN_n,
   input  logic              i_SO,
   input  logic              i_SH1,
   input  logic              i_SH2,
   output logic [WORD_W-1:0] o_L,
   output logic [WORD_W-1:0] o_R,
   output logic              o_L_VALID,
   output logic              o_R_VALID,
   output logic              o_LOCKED,
   output logic              o_FRAME_ERR
);

   rx_state_e         state_q, state_d;
   logic [WORD_W-1:0] shreg_q, shreg_d, l_q, l_d, r_q, r_d;
   logic [WORD_W-1:0] word_c, lin_c;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              sh1_q, sh1_d, sh2_q, sh2_d;
   logic              l_vld_q, l_vld_d, r_vld_q, r_vld_d;
   logic              locked_q, locked_d, err_q, err_d;
   logic              en_c, sh1_fall_c, sh2_fall_c, frame_end_c, sh2_slot_c;
   logic              cap_l_c, cap_r_c, err_c;

   // Edge events; every event is qualified by the phi1 enable.
   always_comb begin
      en_c        = ~i_phi1_PCEN_n;
      word_c      = {i_SO, shreg_q[WORD_W-1:1]};
      sh1_fall_c  = en_c & sh1_q & ~i_SH1;
      sh2_fall_c  = en_c & sh2_q & ~i_SH2;
      frame_end_c = en_c & (cnt_q == CNT_W'(FRAME_LEN - 1));
      sh2_slot_c  = (cnt_q == CNT_W'(SH2_OFFSET - 1));
   end

   always_ff @(posedge i_EMUCLK) begin
      if (i_RST) state_q <= UNLOCKED;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         UNLOCKED: if (sh1_fall_c) state_d = SYNC;
         SYNC:     if (sh1_fall_c && !sh2_fall_c && frame_end_c) state_d = LOCKED;
         LOCKED: begin
            if (sh1_fall_c) begin
               if (sh2_fall_c || !frame_end_c) state_d = SYNC;
            end else if (frame_end_c) begin
               state_d = UNLOCKED;
            end else if (sh2_fall_c && !sh2_slot_c) begin
               state_d = SYNC;
            end
         end
         default: state_d = UNLOCKED;
      endcase
   end

   always_comb begin
      cap_l_c = 1'b0;
      cap_r_c = 1'b0;
      err_c   = 1'b0;
      unique case (state_q)
         SYNC: err_c = sh1_fall_c & (sh2_fall_c | ~frame_end_c);
         LOCKED: begin
            if (sh1_fall_c) begin
               cap_l_c = ~sh2_fall_c & frame_end_c;
               err_c   = sh2_fall_c | ~frame_end_c;
            end else if (frame_end_c) begin
               err_c = 1'b1;
            end else if (sh2_fall_c) begin
               cap_r_c = sh2_slot_c;
               err_c   = ~sh2_slot_c;
            end
         end
         default: ;
      endcase
   end

   // One converter serves both channels; the capture strobe picks the destination.
   ika2151_so_fp2lin #(
      .LINEAR_OUT(LINEAR_OUT)
   ) u_fp2lin (
      .i_word (word_c),
      .o_lin_c(lin_c)
   );

   always_comb begin
      shreg_d  = shreg_q;
      cnt_d    = cnt_q;
      sh1_d    = sh1_q;
      sh2_d    = sh2_q;
      l_d      = cap_l_c ? lin_c : l_q;
      r_d      = cap_r_c ? lin_c : r_q;
      l_vld_d  = cap_l_c;
      r_vld_d  = cap_r_c;
      err_d    = err_c;
      locked_d = (state_d == LOCKED);
      if (en_c) begin
         shreg_d = word_c;
         sh1_d   = i_SH1;
         sh2_d   = i_SH2;
         cnt_d   = sh1_fall_c ? '0 : cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge i_EMUCLK) begin
      if (i_RST) begin
         shreg_q  <= '0;
         cnt_q    <= '0;
         sh1_q    <= 1'b0;
         sh2_q    <= 1'b0;
         l_q      <= '0;
         r_q      <= '0;
         l_vld_q  <= 1'b0;
         r_vld_q  <= 1'b0;
         locked_q <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         shreg_q  <= shreg_d;
         cnt_q    <= cnt_d;
         sh1_q    <= sh1_d;
         sh2_q    <= sh2_d;
         l_q      <= l_d;
         r_q      <= r_d;
         l_vld_q  <= l_vld_d;
         r_vld_q  <= r_vld_d;
         locked_q <= locked_d;
         err_q    <= err_d;
      end
   end

   assign o_L         = l_q;
   assign o_R         = r_q;
   assign o_L_VALID   = l_vld_q;
   assign o_R_VALID   = r_vld_q;
   assign o_LOCKED    = locked_q;
   assign o_FRAME_ERR = err_q;

endmodule

// File: tb/tb_ika2151_so_rx.sv
// Randomised scoreboard bench for ika2151_so_rx against a sample-index based reference model.
module tb_ika2151_so_rx;

   localparam int FRAME = 32;
   localparam int SH2_AT = 16;

   typedef struct {
      bit          lock;
      bit          err;
      bit          lv;
      logic [15:0] l;
      bit          rv;
      logic [15:0] r;
   } exp_t;

   logic        clk, rst, pcen_n, so, sh1, sh2;
   logic [15:0] o_l, o_r;
   logic        o_lv, o_rv, o_locked, o_err;

   int checks, failures;
   exp_t sb[$];

   // reference model state
   bit m_bits[$];
   int m_n, m_anchor, m_mode;
   bit m_p1, m_p2, carry;

   ika2151_so_rx dut (
      .i_EMUCLK     (clk),
      .i_RST        (rst),
      .i_phi1_PCEN_n(pcen_n),
      .i_SO         (so),
      .i_SH1        (sh1),
      .i_SH2        (sh2),
      .o_L          (o_l),
      .o_R          (o_r),
      .o_L_VALID    (o_lv),
      .o_R_VALID    (o_rv),
      .o_LOCKED     (o_locked),
      .o_FRAME_ERR  (o_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%h required=%h t=%0t", name, act, req, $time);
      end
   endtask

   function automatic logic [15:0] conv(input logic [15:0] w);
      int e, sm;
      e  = int'(w[15:13]);
      sm = int'(w[12:3]) - 512;
      if (e == 0) return 16'h0000;
      return 16'(sm * (1 << (e - 1)));
   endfunction

   function automatic logic [15:0] mk(input logic [2:0] e, input logic [9:0] m);
      return {e, m, 3'($urandom_range(0, 7))};
   endfunction

   task automatic model_reset();
      m_bits.delete();
      for (int i = 0; i < 16; i++) m_bits.push_back(1'b0);
      m_n = 0; m_anchor = -1; m_mode = 0;
      m_p1 = 1'b0; m_p2 = 1'b0; carry = 1'b0;
   endtask

   // One phi1 sample: word = last 16 bits (oldest = bit 0), position measured from last SH1 fall.
   task automatic model_step(input bit s, input bit h1, input bit h2);
      exp_t e;
      bit f1, f2, at_end, at_sh2;
      logic [15:0] w;
      int d;
      m_bits.push_back(s);
      void'(m_bits.pop_front());
      for (int i = 0; i < 16; i++) w[i] = m_bits[i];
      f1 = m_p1 && !h1;
      f2 = m_p2 && !h2;
      d = m_n - m_anchor;
      at_end = (d % FRAME) == 0;
      at_sh2 = (d % FRAME) == SH2_AT;
      e.lock = 0; e.err = 0; e.lv = 0; e.l = '0; e.rv = 0; e.r = '0;
      case (m_mode)
         0: if (f1) m_mode = 1;
         1: if (f1) begin
               if (!f2 && at_end) m_mode = 2;
               else e.err = 1;
            end
         default: begin
            if (f1) begin
               if (!f2 && at_end) begin e.lv = 1; e.l = conv(w); end
               else begin e.err = 1; m_mode = 1; end
            end else if (at_end) begin
               e.err = 1; m_mode = 0;
            end else if (f2) begin
               if (at_sh2) begin e.rv = 1; e.r = conv(w); end
               else begin e.err = 1; m_mode = 1; end
            end
         end
      endcase
      if (f1) m_anchor = m_n;
      m_p1 = h1; m_p2 = h2; m_n++;
      e.lock = (m_mode == 2);
      sb.push_back(e);
   endtask

   task automatic sample(input bit s, input bit h1, input bit h2);
      int gap;
      gap = $urandom_range(0, 2);
      repeat (gap) begin
         @(negedge clk);
         pcen_n = 1'b1;
      end
      @(negedge clk);
      pcen_n = 1'b0; so = s; sh1 = h1; sh2 = h2;
      model_step(s, h1, h2);
   endtask

   // Right word occupies positions 1..16, left word 17..32 (bit 15 lands on the next SH1 fall).
   task automatic send_frame(input logic [15:0] wr, input logic [15:0] wl, input int len, input bit sh1_on);
      bit s;
      for (int p = 0; p < len; p++) begin
         if (p == 0)       s = carry;
         else if (p <= 16) s = wr[p - 1];
         else              s = wl[p - 17];
         sample(s, sh1_on && (p >= 8), p < 16);
      end
      carry = wl[15];
   endtask

   task automatic preamble();
      repeat (4) sample(1'b0, 1'b1, 1'b1);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1; pcen_n = 1'b0; sh1 = 1'b1; sh2 = 1'b1;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0; pcen_n = 1'b1;
      model_reset();
   endtask

   // Monitor: reset outputs, per-enable-edge expectations, and quiet/hold between enables.
   initial begin
      bit en_s, rst_s;
      logic [15:0] cur_l, cur_r;
      exp_t e;
      cur_l = '0; cur_r = '0;
      forever begin
         @(posedge clk);
         en_s = !pcen_n; rst_s = rst;
         #1;
         if (rst_s) begin
            cur_l = '0; cur_r = '0;
            chk("reset_outputs", {o_l, o_r}, 32'h0);
            chk("reset_flags", {28'h0, o_lv, o_rv, o_locked, o_err}, 32'h0);
         end else if (en_s) begin
            if (sb.size() == 0) begin
               chk("scoreboard_underflow", 32'd0, 32'd1);
            end else begin
               e = sb.pop_front();
               chk("o_LOCKED", 32'(o_locked), 32'(e.lock));
               chk("o_FRAME_ERR", 32'(o_err), 32'(e.err));
               chk("o_L_VALID", 32'(o_lv), 32'(e.lv));
               chk("o_R_VALID", 32'(o_rv), 32'(e.rv));
               if (e.lv) cur_l = e.l;
               if (e.rv) cur_r = e.r;
               chk("o_L", 32'(o_l), 32'(cur_l));
               chk("o_R", 32'(o_r), 32'(cur_r));
            end
         end else begin
            chk("idle_pulses", {29'h0, o_lv, o_rv, o_err}, 32'h0);
            chk("o_L_hold", 32'(o_l), 32'(cur_l));
            chk("o_R_hold", 32'(o_r), 32'(cur_r));
         end
      end
   end

   initial begin
      checks = 0; failures = 0;
      rst = 1'b1; pcen_n = 1'b1; so = 1'b0; sh1 = 1'b0; sh2 = 1'b0;
      model_reset();
      do_reset();

      // lock up on all-zero words, then the signature conversions
      preamble();
      repeat (3) send_frame(16'h0, 16'h0, FRAME, 1'b1);
      send_frame(mk(3'd7, 10'h000), mk(3'd7, 10'h3FF), FRAME, 1'b1);
      send_frame(16'($urandom), mk(3'd1, 10'h200), FRAME, 1'b1);
      send_frame(16'($urandom), mk(3'd0, 10'h3FF), FRAME, 1'b1);
      send_frame(16'($urandom), mk(3'd3, 10'h201), FRAME, 1'b1);
      send_frame(16'($urandom), 16'($urandom), FRAME, 1'b1);

      // early SH1 fall, then relock
      send_frame(16'($urandom), 16'($urandom), FRAME - 1, 1'b1);
      repeat (4) send_frame(16'($urandom), 16'($urandom), FRAME, 1'b1);

      // SH1 stops toggling, then resumes
      repeat (3) send_frame(16'($urandom), 16'($urandom), FRAME, 1'b0);
      repeat (4) send_frame(16'($urandom), 16'($urandom), FRAME, 1'b1);

      // reset mid-frame while locked
      send_frame(16'($urandom), 16'($urandom), 10, 1'b1);
      do_reset();
      preamble();
      repeat (4) send_frame(16'($urandom), 16'($urandom), FRAME, 1'b1);

      // random words with occasional framing faults
      for (int k = 0; k < 25; k++) begin
         int len;
         bit on;
         len = ($urandom_range(0, 9) == 0) ? int'($urandom_range(30, 33)) : FRAME;
         on  = ($urandom_range(0, 14) != 0);
         send_frame(16'($urandom), 16'($urandom), len, on);
      end
      repeat (3) send_frame(16'($urandom), 16'($urandom), FRAME, 1'b1);

      @(negedge clk);
      pcen_n = 1'b1;
      repeat (5) @(negedge clk);
      chk("scoreboard_drained", 32'(sb.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/ika2151_so_rx.md
Name: ika2151_so_rx

Overview:
- Receiver for the OPM serial audio output stream: SO data framed by SH1/SH2, clocked by phi1.
- Models the YM3012 side of the link: deserialises the two 16-bit floating-point words per frame and converts each to 16-bit signed linear PCM.
- Sits after the timing generator and output serialiser. Drives the core's audio output ports and also serves as a self-check monitor for SH1/SH2 framing.

Parameters:
- FRAME_LEN, 32, phi1 samples between consecutive SH1 falling edges.
- SH2_OFFSET, 16, samples from an SH1 fall to the following SH2 fall.
- LINEAR_OUT, 1, 1 = linear PCM on o_L/o_R; 0 = raw 16-bit serial word passed through.

Ports:
- i_EMUCLK  in  1  emulator master clock
- i_RST  in  1  synchronous reset, active-high
- i_phi1_PCEN_n  in  1  active-low phi1 rising-edge clock enable; all sampling happens on this enable
- i_SO  in  1  serial data
- i_SH1  in  1  channel-1 (left) word strobe
- i_SH2  in  1  channel-2 (right) word strobe
- o_L  out  16  signed left sample
- o_R  out  16  signed right sample
- o_L_VALID  out  1  one-EMUCLK pulse when o_L updates
- o_R_VALID  out  1  one-EMUCLK pulse when o_R updates
- o_LOCKED  out  1  framing locked
- o_FRAME_ERR  out  1  one-EMUCLK pulse on a framing violation

Behaviour:
- Sampling is qualified by an enable edge: an EMUCLK edge with i_phi1_PCEN_n = 0. Nothing changes on other edges, except that valid and error pulses clear.
- i_RST is synchronous and active-high, and overrides the enable. On reset:
  - o_L, o_R = 0; all pulses = 0; o_LOCKED = 0.
  - Shift register = 0; sample counter = 0; SH history = 0; state = UNLOCKED.
- Shift register: 16 bits. On each enable edge it shifts right with i_SO entering bit 15 (the stream is LSB first). After 16 shifts, bit 0 holds the first bit received.
- SH history: i_SH1 and i_SH2 are registered on each enable edge. A fall is previous = 1 and current = 0, evaluated on the same enable edge.
- Word capture: at a fall, the word is the shift register value including the bit shifted in at that edge.
- Word format:
  - bits[2:0] are ignored.
  - M = bits[12:3] is the mantissa, offset binary; signed mantissa = {~M[9], M[8:0]}.
  - E = bits[15:13] is the exponent.
- Conversion (LINEAR_OUT = 1):
  - E = 0: output 0.
  - Otherwise: output = sign-extend(signed mantissa) << (E-1), truncated to 16 bits. E = 7 uses the full range with no overflow.
- Conversion (LINEAR_OUT = 0): output = raw word.
- Sample counter: 5 bits, increments every enable edge. It is set to 0 at every SH1 fall, then wraps 31 -> 0.
- State machine:
  - UNLOCKED: the first SH1 fall goes to SYNC and zeroes the counter. No captures.
  - SYNC: an SH1 fall with counter == FRAME_LEN-1 goes to LOCKED (o_LOCKED = 1 from the next EMUCLK). An SH1 fall at any other count pulses o_FRAME_ERR and stays in SYNC with the counter zeroed.
  - LOCKED, SH1 fall at counter == FRAME_LEN-1: capture left. o_L is registered at that edge and o_L_VALID is high for the following single EMUCLK cycle.
  - LOCKED, SH2 fall at counter == SH2_OFFSET-1: capture right, same timing, on o_R/o_R_VALID.
  - LOCKED, misplaced SH1 or SH2 fall: o_FRAME_ERR pulse, go to SYNC, no capture, outputs hold. A misplaced SH1 fall also zeroes the counter.
  - LOCKED, counter reaches FRAME_LEN-1 with no SH1 fall on that edge: o_FRAME_ERR pulse, go to UNLOCKED.
- Simultaneous SH1 and SH2 falls: both are misplaced, so one error pulse and go to SYNC.
- Latency: each sample is available 1 EMUCLK after its strobe-fall enable edge.
- Reset mid-word: the partial word is discarded; relock requires 2 SH1 falls.

Decomposition:
- Shared package ika2151_pkg holds:
  - SO word field constants: MANT_LSB = 3, MANT_MSB = 12, EXP_LSB = 13.
  - The rx state enum (UNLOCKED, SYNC, LOCKED).
- Sub-module ika2151_so_fp2lin: combinational 16-bit word -> signed linear converter, instantiated once and shared by L/R through a select.

Test Plan:
- Reset, then 3 clean frames of all-zero words -> o_LOCKED rises after the 2nd SH1 fall; first o_L_VALID occurs at the 3rd SH1 fall; o_L = o_R = 0.
- Locked; left word E = 7, M = 10'h3FF -> o_L = 16'h7FC0. Right word E = 7, M = 10'h000 -> o_R = 16'h8000.
- Left word E = 1, M = 10'h200 -> o_L = 0. E = 0, M = 10'h3FF -> o_L = 0. E = 3, M = 10'h201 -> o_L = 16'h0004.
- Locked; shift SH1 fall one sample early -> one o_FRAME_ERR pulse, o_LOCKED drops, o_L holds; relocked after the next correct period.
- Stop SH1 toggling -> o_FRAME_ERR pulse at count 31, state UNLOCKED, no further VALID pulses.
- i_RST asserted mid-frame while locked -> all outputs 0 on the next EMUCLK; VALID pulses resume only after 2 good SH1 periods.
